// File: rtl/countdown_timer.sv
// Loadable down-counter with built-in tick prescaler and one-cycle done pulse.
// Define COUNTDOWN_AUTORELOAD_EN to reload from the last loaded value on completion.
module countdown_timer #(
    parameter int WIDTH = 4,
    parameter int DIV   = 500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

`ifdef COUNTDOWN_AUTORELOAD_EN
    localparam bit AUTORELOAD = 1'b1;
`else
    localparam bit AUTORELOAD = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED
    } state_t;

    state_t           state, state_d;
    logic [PW-1:0]    presc, presc_d;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] reload, reload_d;
    logic             busy_d, done_d;

    always_comb begin
        // NOTE: every output of this block gets a hold/default value first so no latch is inferred.
        state_d  = state;
        presc_d  = presc;
        out_d    = out;
        reload_d = reload;
        done_d   = 1'b0;

        if (load) begin
            out_d    = load_val;
            reload_d = load_val;
            presc_d  = '0;
            state_d  = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && out != '0) begin
                        state_d = RUN;
                        presc_d = '0;
                    end
                end
                RUN: begin
                    // start outranks pause, so both together keep the count running
                    if (pause && !start) begin
                        state_d = PAUSED;
                    end else if (presc == PRESC_MAX) begin
                        presc_d = '0;
                        if (out == WIDTH'(1)) begin
                            done_d  = 1'b1;
                            out_d   = AUTORELOAD ? reload : '0;
                            state_d = AUTORELOAD ? RUN : IDLE;
                        end else if (out != '0) begin
                            out_d = out - WIDTH'(1);
                        end
                    end else begin
                        presc_d = presc + PW'(1);
                    end
                end
                PAUSED: begin
                    if (start) state_d = RUN;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            presc  <= '0;
            out    <= '0;
            reload <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_d;
            presc  <= presc_d;
            out    <= out_d;
            reload <= reload_d;
            busy   <= busy_d;
            done   <= done_d;
        end
    end

endmodule
